// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined segment adder.
package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } add_mode_e;

  // Signed overflow of a two's-complement add: carry into MSB differs from carry out of MSB.
  function automatic logic signed_overflow(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/carry_segment.sv
// Combinational SEG-bit ripple full-adder chain; one instance per pipeline stage.
module carry_segment #(
  parameter int unsigned SEG = 2
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] c;

  // Ripple the carry through the segment bit by bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined add/sub: one SEG-bit ripple segment per stage, operands skewed in,
// result segments accumulated so the full word leaves aligned after STAGES cycles.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned SEG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic         carry_in,
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int unsigned SEG_SAFE = (SEG == 0) ? 1 : SEG;
  localparam int unsigned STAGES   = ((N / SEG_SAFE) == 0) ? 1 : (N / SEG_SAFE);
  localparam bit          CFG_OK   = (SEG >= 1) && (N >= SEG) && ((N % SEG_SAFE) == 0);

  // Reject geometries where the word does not split into whole segments.
  if (!CFG_OK) begin : g_bad_cfg
    $fatal(1, "pipelined_segment_adder: N must be a nonzero multiple of SEG");
  end

  logic              adv_c;
  logic [N-1:0]      b_eff;
  logic              cin_eff;

  // Per-stage sources: stage 0 is fed from the ports, stage k from register k-1.
  logic [N-1:0]      src_a [STAGES];
  logic [N-1:0]      src_b [STAGES];
  logic [N-1:0]      src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] ld_c;

  logic [SEG-1:0]    seg_s  [STAGES];
  logic [STAGES-1:0] seg_co;
  logic              seg_cm [STAGES];

  // Pipeline registers; operands are kept pre-shifted so each stage reads its segment at the LSBs.
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      a_d [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      b_d [STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic [N-1:0]      s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;

  // Whole pipe moves only when the output slot is free or being drained.
  assign adv_c    = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv_c;

  // Subtraction as op1 + ~op2 + 1.
  assign b_eff   = (add_mode_e'(mode) == SUB) ? ~op2 : op2;
  assign cin_eff = (add_mode_e'(mode) == SUB) ? 1'b1 : carry_in;

  // A stage loads new data only for a real beat, so bubbles leave stale data in place.
  assign ld_c = adv_c ? src_v : '0;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k] = op1;
      assign src_b[k] = b_eff;
      assign src_s[k] = '0;
      assign src_c[k] = cin_eff;
      assign src_v[k] = in_valid;
    end else begin : g_next
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_v[k] = v_q[k-1];
    end

    carry_segment #(.SEG(SEG)) u_seg (
      .a     (src_a[k][SEG-1:0]),
      .b     (src_b[k][SEG-1:0]),
      .cin   (src_c[k]),
      .s     (seg_s[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  // Next-state for every stage: shift operands, merge the resolved segment, pass the carry.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    c_d   = c_q;
    v_d   = v_q;
    ovf_d = ovf_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (adv_c) begin
        v_d[k] = src_v[k];
      end
      if (ld_c[k]) begin
        a_d[k]                = src_a[k] >> SEG;
        b_d[k]                = src_b[k] >> SEG;
        s_d[k]                = src_s[k];
        s_d[k][k*SEG +: SEG]  = seg_s[k];
        c_d[k]                = seg_co[k];
      end
    end
    if (ld_c[STAGES-1]) begin
      ovf_d = signed_overflow(seg_cm[STAGES-1], seg_co[STAGES-1]);
    end
  end

  // Pipeline state; reset drops every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench: an 8-bit/2-bit-segment instance for directed and random traffic,
// and a 4-bit/1-bit-segment instance for an exhaustive sweep.
module tb_pipelined_segment_adder;

  localparam int NA = 8;
  localparam int SA = 2;
  localparam int STA = NA / SA;
  localparam int NB = 4;
  localparam int SB = 1;
  localparam int STB = NB / SB;

  typedef struct {
    logic [7:0] sum;
    logic       co;
    logic       ovf;
    int         acc;
    bit         chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_mode, a_cin, a_out_valid, a_out_ready, a_co, a_ovf;
  logic [NA-1:0] a_op1, a_op2, a_sum;
  logic          b_in_valid, b_in_ready, b_mode, b_cin, b_out_valid, b_out_ready, b_co, b_ovf;
  logic [NB-1:0] b_op1, b_op2, b_sum;

  pipelined_segment_adder #(.N(NA), .SEG(SA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
    .carry_in(a_cin), .op1(a_op1), .op2(a_op2), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sum(a_sum), .carry_out(a_co), .overflow(a_ovf)
  );

  pipelined_segment_adder #(.N(NB), .SEG(SB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
    .carry_in(b_cin), .op1(b_op1), .op2(b_op2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum(b_sum), .carry_out(b_co), .overflow(b_ovf)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_model(input int n, input bit sub, input bit cin, input int x, input int y);
    exp_t e;
    int lim  = 1 << n;
    int half = lim / 2;
    int sx   = (x >= half) ? x - lim : x;
    int sy   = (y >= half) ? y - lim : y;
    int ideal;
    ideal = sub ? (sx - sy) : (sx + sy + int'(cin));
    e.ovf = (ideal < -half) || (ideal > half - 1);
    if (sub) begin
      e.co  = (x >= y);
      e.sum = 8'((x - y + lim) % lim);
    end else begin
      e.co  = ((x + y + int'(cin)) >= lim);
      e.sum = 8'((x + y + int'(cin)) % lim);
    end
    e.acc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input bit sub, input bit cin, input int x, input int y, input bit lat);
    exp_t e;
    int   n = 0;
    a_in_valid = 1'b1; a_mode = sub; a_cin = cin; a_op1 = 8'(x); a_op2 = 8'(y);
    @(negedge clk);
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: in_ready stayed 0 for %0d cycles", n);
      a_in_valid = 1'b0;
      return;
    end
    e = ref_model(NA, sub, cin, x, y);
    e.acc = cyc; e.chk_lat = lat;
    qa.push_back(e);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(input bit sub, input bit cin, input int x, input int y);
    exp_t e;
    int   n = 0;
    b_in_valid = 1'b1; b_mode = sub; b_cin = cin; b_op1 = 4'(x); b_op2 = 4'(y);
    @(negedge clk);
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout: in_ready stayed 0 for %0d cycles", n);
      b_in_valid = 1'b0;
      return;
    end
    e = ref_model(NB, sub, cin, x, y);
    e.acc = cyc; e.chk_lat = 1'b1;
    qb.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  // Monitor for the 8-bit instance: pop on every output handshake.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: beat sum=%0d with empty scoreboard", a_sum);
      end else begin
        ea = qa.pop_front();
        check("a_sum", int'(a_sum), int'(ea.sum));
        check("a_carry_out", int'(a_co), int'(ea.co));
        check("a_overflow", int'(a_ovf), int'(ea.ovf));
        if (ea.chk_lat) check("a_latency", cyc - ea.acc, STA);
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: beat sum=%0d with empty scoreboard", b_sum);
      end else begin
        eb = qb.pop_front();
        check("b_sum", int'(b_sum), int'(eb.sum[3:0]));
        check("b_carry_out", int'(b_co), int'(eb.co));
        check("b_overflow", int'(b_ovf), int'(eb.ovf));
        check("b_latency", cyc - eb.acc, STB);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NA-1:0] hold_sum;
    logic          hold_co, hold_ovf;
    bit            rdone;
    int            n;

    rst = 1'b1;
    a_in_valid = 1'b0; a_mode = 1'b0; a_cin = 1'b0; a_op1 = '0; a_op2 = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_mode = 1'b0; b_cin = 1'b0; b_op1 = '0; b_op2 = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_sum", int'(a_sum), 0);
    check("rst_carry_out", int'(a_co), 0);
    check("rst_overflow", int'(a_ovf), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(a_in_ready), 1);

    // Single ADD with directed latency and value checks.
    drive_a(1'b0, 1'b1, 200, 100, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("add_not_early", int'(a_out_valid), 0);
    @(posedge clk); #1;
    check("add_valid_at_4", int'(a_out_valid), 1);
    check("add_sum_45", int'(a_sum), 45);
    check("add_carry_1", int'(a_co), 1);
    check("add_ovf_0", int'(a_ovf), 0);
    repeat (3) @(posedge clk);
    #1;

    // Subtraction corner cases.
    drive_a(1'b1, 1'b0, 8'h80, 8'h01, 1'b1);
    drive_a(1'b1, 1'b1, 3, 5, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back stream.
    for (int i = 0; i < 16; i++) drive_a(1'b0, 1'b0, i, 2 * i, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Stall with a full pipe.
    fork
      begin
        for (int i = 0; i < 10; i++)
          drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        hold_sum = a_sum; hold_co = a_co; hold_ovf = a_ovf;
        check("stall_in_ready", int'(a_in_ready), 0);
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check("stall_in_ready", int'(a_in_ready), 0);
          check("stall_out_valid", int'(a_out_valid), 1);
          check("stall_sum_stable", int'(a_sum), int'(hold_sum));
          check("stall_co_stable", int'(a_co), int'(hold_co));
          check("stall_ovf_stable", int'(a_ovf), int'(hold_ovf));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Reset with three beats in flight.
    drive_a(1'b0, 1'b0, 11, 22, 1'b0);
    drive_a(1'b0, 1'b1, 33, 44, 1'b0);
    drive_a(1'b1, 1'b0, 99, 7, 1'b0);
    rst = 1'b1;
    qa.delete();
    #1;
    check("async_rst_out_valid", int'(a_out_valid), 0);
    check("async_rst_sum", int'(a_sum), 0);
    check("async_rst_co", int'(a_co), 0);
    check("async_rst_ovf", int'(a_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(1'b0, 1'b0, 77, 88, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Random traffic under random backpressure.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++)
          drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 3) != 0);
        end
        a_out_ready = 1'b1;
      end
    join

    // Exhaustive sweep on the 4-bit, 1-bit-segment instance.
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            drive_b(1'(m), 1'(c), x, y);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_a_empty", qa.size(), 0);
    check("drain_b_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_segment_adder.md
Name: pipelined_segment_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder. Supports add and subtract.
- Splits an N-bit operation into STAGES = N/SEG segments. Each pipeline stage resolves one SEG-bit ripple segment and registers the carry into the next stage.
- Input operands are skewed into the pipeline and result segments are deskewed, so the result appears aligned on the output.
- Valid/ready handshake at both ends. Sits between operand producers and datapath consumers that need fixed-latency, high-Fmax addition.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of SEG and ≥ SEG.
- SEG, 2, bits resolved per pipeline stage (ripple length per stage); STAGES = N/SEG, derived localparam.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- mode  input  1  0 = ADD, 1 = SUB (encoding from package).
- carry_in  input  1  carry into LSB for ADD; ignored for SUB.
- op1  input  N  first operand.
- op2  input  N  second operand.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result bits.
- carry_out  output  1  carry out of MSB; for SUB, 1 = no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset: asynchronous, active-high. Clears all stage valid bits, skew/deskew registers and carries. While rst is high: out_valid=0, sum=0, carry_out=0, overflow=0.
  - in_ready = 1 after rst deasserts.
  - A reset asserted mid-operation discards all in-flight beats; nothing is emitted for them.
- Advance: adv = !out_valid || out_ready. in_ready = adv, combinational and with no dependence on in_valid.
- Accept: a beat is accepted when in_valid && in_ready.
- SUB encoding at accept: op2 is inverted and the effective carry into bit 0 is 1. ADD uses op2 as given with carry_in.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Operand segments for stage k are delayed k cycles.
  - The result segment from stage k is delayed STAGES-1-k cycles.
- Latency: exactly STAGES cycles from accept to out_valid, with no stalls. Throughput is 1 beat/cycle while out_ready=1.
- Stall: when adv=0 every pipeline register holds, including bubbles; bubbles are not collapsed. sum, carry_out and overflow stay stable while out_valid && !out_ready.
- Simultaneous accept and output handshake in the same cycle: both occur and the pipeline shifts by one.
- When out_valid=0, sum/carry_out/overflow hold their last value; this is don't-care for the consumer.
- Arithmetic: {carry_out, sum} = op1 + op2 + carry_in (mod 2^(N+1)) for ADD. For SUB, sum = op1 - op2 mod 2^N.
- overflow is the signed two's-complement overflow of that same operation.
- Width rules: no truncation is hidden; the N+1-bit result is always recoverable as {carry_out, sum}.
- Elaboration errors: N % SEG != 0 or SEG < 1 is a fatal elaboration-time error (static assertion).
- SEG = N: single stage, latency 1.

Decomposition:
- Package adder_pkg:
  - typedef enum logic {ADD=1'b0, SUB=1'b1} add_mode_e.
  - Function for the signed-overflow calculation.
- Sub-module carry_segment: combinational SEG-bit full-adder chain. Inputs: a, b, cin. Outputs: s, cout, and carry into its MSB (needed for overflow in the top segment).
  - Instantiated STAGES times via generate.
  - All pipeline registers stay in the top module.

Test Plan (N=8, SEG=2, STAGES=4):
- ADD 8'd200 + 8'd100, carry_in=1, out_ready=1 -> exactly 4 cycles later: out_valid=1, sum=8'd45, carry_out=1, overflow=0.
- SUB 8'h80 - 8'h01 -> sum=8'h7F, carry_out=1, overflow=1. Then SUB 8'd3 - 8'd5 -> sum=8'hFE, carry_out=0, overflow=0.
- Back-to-back stream of 16 ADD beats (i, 2i), out_ready=1 -> 16 consecutive out_valid cycles, results in order, sum=3i mod 256.
- Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs stable across the stall. On release, the remaining beats drain in order with no loss or duplicate.
- Assert rst for 1 cycle with 3 beats in flight -> outputs 0 immediately (asynchronous), no stale beat emitted afterward, new beat returns after 4 cycles.
- Exhaustive sweep at N=4, SEG=1, both modes, carry_in 0/1 -> every {carry_out, sum} and overflow match the reference-model arithmetic.
